mma_oa_drain_ctrl: RTL and testbench

Sequencer that drains the MMA output-activation ping-pong FIFO into memory for one tile job at a time. It answers the FIFO's batch request with the column count, pops 32-bit packed words, converts them into masked memory write commands with row-strided addresses, tracks outstanding writes and reports completion. It sits between the MMA control CSRs, the s8 output FIFO and the memory write port of the EAI subsystem.

---
 rtl/mma_oa_pkg.sv | 24 ++
 rtl/mma_oa_addr_gen.sv | 47 ++++
 rtl/mma_oa_drain_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mma_oa_drain_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mma_oa_pkg.sv
// Shared FSM encoding and sizing helpers for the MMA output-activation drain sequencer.
package mma_oa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_REQ,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int MAX_OUTS_DEF = 4;

    // Row counter must hold 0..VLEN inclusive.
    function automatic int row_cnt_w(input int vlen);
        return $clog2(vlen) + 1;
    endfunction

    // Outstanding counter must hold 0..MAX_OUTS inclusive.
    function automatic int outs_cnt_w(input int max_outs);
        return $clog2(max_outs + 1);
    endfunction

endpackage

// File: rtl/mma_oa_addr_gen.sv
// Row/word position tracking and write address generation; address is combinational from registers.
// Advances only on pop, so a stalled command keeps a stable address.
module mma_oa_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int ROW_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic              pop,
    input  logic              row_switch,
    output logic [ADDR_W-1:0] addr,
    output logic [ROW_W-1:0]  row
);

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] word_off;
    logic [ADDR_W-1:0] stride;

    // row_base accumulates base + row*stride incrementally, avoiding a multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base <= '0;
            word_off <= '0;
            stride   <= '0;
            row      <= '0;
        end else if (load) begin
            row_base <= base_addr;
            word_off <= '0;
            stride   <= row_stride;
            row      <= '0;
        end else if (pop) begin
            if (row_switch) begin
                row_base <= row_base + stride;
                word_off <= '0;
                row      <= row + ROW_W'(1);
            end else begin
                word_off <= word_off + ADDR_W'(4);
            end
        end
    end

    assign addr = row_base + word_off;

endmodule

// File: rtl/mma_oa_drain_ctrl.sv
// Drains the OA FIFO into masked row-strided memory writes; zero-latency FIFO-to-command path, pops only on
// command accept (or zero mask) while fewer than MAX_OUTS writes are outstanding. Optional MMA_OA_DRAIN_PERF_EN.
module mma_oa_drain_ctrl
    import mma_oa_pkg::*;
#(
    parameter int VLEN     = 16,
    parameter int ADDR_W   = 32,
    parameter int MAX_OUTS = MAX_OUTS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [ADDR_W-1:0]     cfg_row_stride,
    input  logic [$clog2(VLEN):0] cfg_num_rows,
    input  logic [(VLEN>>2)-1:0]  cfg_num_col,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
`ifdef MMA_OA_DRAIN_PERF_EN
    output logic [31:0]           perf_stall_cyc,
    output logic [31:0]           perf_word_cnt,
`endif
    input  logic                  fifo_req,
    output logic [(VLEN>>2)-1:0]  fifo_num_col,
    input  logic                  fifo_valid,
    output logic                  fifo_ready,
    input  logic                  fifo_row_switch,
    input  logic [3:0]            fifo_mask,
    input  logic [31:0]           fifo_data,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic [ADDR_W-1:0]     mem_cmd_addr,
    output logic [31:0]           mem_cmd_wdata,
    output logic [3:0]            mem_cmd_wmask,
    input  logic                  mem_rsp_valid,
    input  logic                  mem_rsp_err
);

    localparam int ROW_W = row_cnt_w(VLEN);
    localparam int CNT_W = outs_cnt_w(MAX_OUTS);
    localparam int COL_W = VLEN >> 2;

    state_t           state;
    logic [ROW_W-1:0] num_rows_q;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] num_col_q;
    logic [CNT_W-1:0] outs_cnt;

    logic start_acc;
    logic in_stream;
    logic issue;
    logic has_data;
    logic cmd_hs;
    logic rsp_take;
    logic last_pop;

    assign start_acc = (state == ST_IDLE) && cfg_start;
    assign in_stream = (state == ST_STREAM);
    assign issue     = in_stream && fifo_valid && (outs_cnt < CNT_W'(MAX_OUTS));
    assign has_data  = (fifo_mask != 4'h0);

    assign mem_cmd_valid = issue && has_data;
    assign fifo_ready    = issue && (mem_cmd_ready || !has_data);
    assign mem_cmd_wdata = fifo_data;
    assign mem_cmd_wmask = fifo_mask;
    assign fifo_num_col  = busy ? num_col_q : '0;

    assign cmd_hs   = mem_cmd_valid && mem_cmd_ready;
    // A response with nothing outstanding (e.g. in flight across a reset) is dropped entirely.
    assign rsp_take = mem_rsp_valid && (outs_cnt != '0);
    assign last_pop = fifo_ready && fifo_row_switch && (row == num_rows_q - ROW_W'(1));

    mma_oa_addr_gen #(
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (start_acc),
        .base_addr  (cfg_base_addr),
        .row_stride (cfg_row_stride),
        .pop        (fifo_ready),
        .row_switch (fifo_row_switch),
        .addr       (mem_cmd_addr),
        .row        (row)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            outs_cnt   <= '0;
            num_rows_q <= '0;
            num_col_q  <= '0;
        end else begin
            done <= 1'b0;

            case ({cmd_hs, rsp_take})
                2'b10:   outs_cnt <= outs_cnt + CNT_W'(1);
                2'b01:   outs_cnt <= outs_cnt - CNT_W'(1);
                default: ;
            endcase

            if (rsp_take && mem_rsp_err) begin
                err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        num_rows_q <= cfg_num_rows;
                        num_col_q  <= cfg_num_col;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        if (cfg_num_rows == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_WAIT_REQ;
                        end
                    end
                end
                ST_WAIT_REQ: begin
                    if (fifo_req) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (last_pop) begin
                        state <= ST_DRAIN;
                    end else if (!fifo_valid) begin
                        state <= ST_WAIT_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (outs_cnt == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MMA_OA_DRAIN_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_word_cnt  <= '0;
        end else if (start_acc) begin
            perf_stall_cyc <= '0;
            perf_word_cnt  <= '0;
        end else begin
            if (in_stream && fifo_valid && !fifo_ready && (perf_stall_cyc != '1)) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (cmd_hs && (perf_word_cnt != '1)) begin
                perf_word_cnt <= perf_word_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mma_oa_drain_ctrl.sv
// Directed-plus-random bench for mma_oa_drain_ctrl: FIFO driver, memory responder and a scoreboard
// whose expected writes come from the row/word/mask rules, not from the RTL structure.
module tb_mma_oa_drain_ctrl;

    localparam int VLEN     = 16;
    localparam int ADDR_W   = 32;
    localparam int MAX_OUTS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [31:0] cfg_row_stride = '0;
    logic [4:0]  cfg_num_rows = '0;
    logic [3:0]  cfg_num_col = '0;
    logic        busy, done, err;
    logic        fifo_req = 1'b0;
    logic [3:0]  fifo_num_col;
    logic        fifo_valid = 1'b0;
    logic        fifo_ready;
    logic        fifo_row_switch = 1'b0;
    logic [3:0]  fifo_mask = '0;
    logic [31:0] fifo_data = '0;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready = 1'b0;
    logic [31:0] mem_cmd_addr, mem_cmd_wdata;
    logic [3:0]  mem_cmd_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic        mem_rsp_err = 1'b0;
`ifdef MMA_OA_DRAIN_PERF_EN
    logic [31:0] perf_stall_cyc, perf_word_cnt;
`endif

    mma_oa_drain_ctrl #(.VLEN(VLEN), .ADDR_W(ADDR_W), .MAX_OUTS(MAX_OUTS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_start       (cfg_start),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_row_stride  (cfg_row_stride),
        .cfg_num_rows    (cfg_num_rows),
        .cfg_num_col     (cfg_num_col),
        .busy            (busy),
        .done            (done),
        .err             (err),
`ifdef MMA_OA_DRAIN_PERF_EN
        .perf_stall_cyc  (perf_stall_cyc),
        .perf_word_cnt   (perf_word_cnt),
`endif
        .fifo_req        (fifo_req),
        .fifo_num_col    (fifo_num_col),
        .fifo_valid      (fifo_valid),
        .fifo_ready      (fifo_ready),
        .fifo_row_switch (fifo_row_switch),
        .fifo_mask       (fifo_mask),
        .fifo_data       (fifo_data),
        .mem_cmd_valid   (mem_cmd_valid),
        .mem_cmd_ready   (mem_cmd_ready),
        .mem_cmd_addr    (mem_cmd_addr),
        .mem_cmd_wdata   (mem_cmd_wdata),
        .mem_cmd_wmask   (mem_cmd_wmask),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_err     (mem_rsp_err)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail = 0;
    int  done_cnt = 0, hs_cnt = 0, traffic_cnt = 0;
    int  pending = 0, rsp_idx = 0, err_idx = -1, model_outs = 0;
    int  ready_mode = 0, stall_left = 0, stall_at = 0;
    bit  stall_armed = 0, rsp_hold = 0, abort = 0, prev_stall = 0;
    logic [63:0] prev_cmd;
    logic [67:0] got_q[$];

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples on the falling edge, i.e. what the DUT will act on at the next rising edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            model_outs = 0;
            prev_stall = 0;
        end else begin
            if (done) done_cnt++;
            if (fifo_ready || mem_cmd_valid) traffic_cnt++;
            if (mem_cmd_valid) check("outs_limit", 72'(model_outs < MAX_OUTS), 72'd1);
            if (mem_cmd_valid && !mem_cmd_ready) begin
                check("stall_no_pop", 72'(fifo_ready), 72'd0);
                if (prev_stall) check("stall_hold", 72'({mem_cmd_addr, mem_cmd_wdata}), 72'(prev_cmd));
                prev_stall = 1;
                prev_cmd   = {mem_cmd_addr, mem_cmd_wdata};
            end else begin
                prev_stall = 0;
            end
            if (mem_rsp_valid && model_outs > 0) model_outs--;
            if (mem_cmd_valid && mem_cmd_ready) begin
                got_q.push_back({mem_cmd_addr, mem_cmd_wdata, mem_cmd_wmask});
                hs_cnt++;
                pending++;
                model_outs++;
            end
        end
    end

    // Memory model: one response per cycle for accepted writes, with optional hold, error and ready stalls.
    initial forever begin
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        if (rst_n && !rsp_hold && pending > 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_err   = (rsp_idx == err_idx);
            rsp_idx++;
            pending--;
        end
        if (stall_armed && hs_cnt >= stall_at) begin
            stall_armed = 0;
            stall_left  = 5;
        end
        if (stall_left > 0) begin
            mem_cmd_ready = 1'b0;
            stall_left--;
        end else if (ready_mode == 1) begin
            mem_cmd_ready = 1'($urandom_range(0, 1));
        end else begin
            mem_cmd_ready = 1'b1;
        end
    end

    task automatic run_job(input logic [31:0] base, input logic [31:0] stride, input int rows,
                           input int ncol, input bit zmask, input bit gaps, input bit err_exp,
                           input string tag);
        logic [36:0] stim_q[$];
        logic [67:0] exp_q[$];
        logic [3:0]  m;
        logic [31:0] d;
        int nb, nw, n, d0, t0;
        bit p;
        nb = ncol + 1;
        nw = (nb + 3) / 4;
        for (int r = 0; r < rows; r++) begin
            for (int w = 0; w < nw; w++) begin
                m = (w == nw - 1 && nb % 4 != 0) ? 4'((1 << (nb % 4)) - 1) : 4'hF;
                if (zmask && $urandom_range(0, 3) == 0) m = 4'h0;
                d = $urandom;
                stim_q.push_back({d, m, 1'(w == nw - 1)});
                if (m != 4'h0) exp_q.push_back({base + 32'(r) * stride + 32'(w * 4), d, m});
            end
        end
        @(posedge clk);
        #1;
        got_q.delete();
        d0 = done_cnt;
        t0 = traffic_cnt;
        cfg_base_addr  = base;
        cfg_row_stride = stride;
        cfg_num_rows   = 5'(rows);
        cfg_num_col    = 4'(ncol);
        cfg_start      = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        check({tag, "_busy"}, 72'(busy), 72'd1);
        check({tag, "_err_clr"}, 72'(err), 72'd0);
        check({tag, "_num_col"}, 72'(fifo_num_col), 72'(ncol));
        // Scramble cfg inputs so any use of unlatched values shows up in the scoreboard.
        cfg_base_addr  = $urandom;
        cfg_row_stride = $urandom;
        cfg_num_rows   = 5'($urandom_range(0, 16));
        cfg_num_col    = 4'($urandom);
        fifo_req = 1'b1;
        foreach (stim_q[i]) begin
            if (abort) break;
            if (gaps && i > 0 && stim_q[i-1][0] && $urandom_range(0, 1) == 1) begin
                fifo_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            fifo_valid = 1'b1;
            {fifo_data, fifo_mask, fifo_row_switch} = stim_q[i];
            n = 0;
            p = 0;
            while (!p && n < 500 && !abort) begin
                @(negedge clk);
                p = fifo_ready;
                n++;
            end
            if (!abort) check({tag, "_pop_timeout"}, 72'(p), 72'd1);
            if (!p) break;
            @(posedge clk);
            #1;
        end
        fifo_valid = 1'b0;
        fifo_req   = 1'b0;
        if (abort) return;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rows == 0) check({tag, "_fast_done"}, 72'(n <= 2), 72'd1);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_done_cnt"}, 72'(done_cnt - d0), 72'd1);
        check({tag, "_idle"}, 72'(busy), 72'd0);
        check({tag, "_num_col_idle"}, 72'(fifo_num_col), 72'd0);
        check({tag, "_err"}, 72'(err), 72'(err_exp));
        if (rows == 0) check({tag, "_no_traffic"}, 72'(traffic_cnt - t0), 72'd0);
        check({tag, "_wr_cnt"}, 72'(got_q.size()), 72'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check($sformatf("%s_wr%0d", tag, i), 72'(got_q[i]), 72'(exp_q[i]));
        end
`ifdef MMA_OA_DRAIN_PERF_EN
        check({tag, "_perf_words"}, 72'(perf_word_cnt), 72'(exp_q.size()));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, d0, n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 72'(busy), 72'd0);
        check("rst_done", 72'(done), 72'd0);
        check("rst_err", 72'(err), 72'd0);
        check("rst_fifo_ready", 72'(fifo_ready), 72'd0);
        check("rst_cmd_valid", 72'(mem_cmd_valid), 72'd0);
        check("rst_cmd_addr", 72'(mem_cmd_addr), 72'd0);
        check("rst_num_col", 72'(fifo_num_col), 72'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_job(32'h1000, 32'h40, 2, 15, 0, 0, 0, "basic");
        run_job(32'h3000, 32'h20, 3, 5, 0, 0, 0, "partial");

        stall_at    = hs_cnt + 2;
        stall_armed = 1;
        run_job(32'h4000, 32'h40, 2, 15, 0, 0, 0, "stall");

        rsp_hold = 1;
        h0 = hs_cnt;
        d0 = done_cnt;
        fork
            run_job(32'h5000, 32'h40, 2, 15, 0, 0, 0, "hold");
            begin
                repeat (40) @(negedge clk);
                #1;
                check("hold_issued", 72'(hs_cnt - h0), 72'(MAX_OUTS));
                check("hold_cmd_valid", 72'(mem_cmd_valid), 72'd0);
                check("hold_no_done", 72'(done_cnt - d0), 72'd0);
                cfg_start = 1'b1;
                @(posedge clk);
                #1;
                cfg_start = 1'b0;
                check("hold_busy", 72'(busy), 72'd1);
                rsp_hold = 0;
            end
        join

        run_job(32'h6000, 32'h40, 0, 15, 0, 0, 0, "rows0");

        err_idx = rsp_idx + 2;
        run_job(32'h7000, 32'h40, 2, 11, 0, 0, 1, "wr_err");
        err_idx = -1;
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", 72'(err), 72'd1);
        run_job(32'h7100, 32'h40, 1, 3, 0, 0, 0, "err_cleared");

        run_job(32'hFFFF_FFF0, 32'h10, 3, 15, 1, 0, 0, "wrap");

        ready_mode = 1;
        for (int k = 0; k < 4; k++) begin
            run_job($urandom & 32'hFFFF_FFFC, ($urandom_range(0, 255)) << 2,
                    $urandom_range(1, 16), $urandom_range(0, 15), 1, 1, 0, $sformatf("rnd%0d", k));
        end
        ready_mode = 0;

        h0 = hs_cnt;
        fork
            run_job(32'h2000, 32'h80, 4, 15, 0, 0, 0, "rst");
            begin
                n = 0;
                while (hs_cnt < h0 + 3 && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                check("rst_reach_stream", 72'(hs_cnt - h0 >= 3), 72'd1);
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                abort = 1;
                #1;
                check("mid_rst_busy", 72'(busy), 72'd0);
                check("mid_rst_done", 72'(done), 72'd0);
                check("mid_rst_err", 72'(err), 72'd0);
                check("mid_rst_fifo_ready", 72'(fifo_ready), 72'd0);
                check("mid_rst_cmd_valid", 72'(mem_cmd_valid), 72'd0);
                check("mid_rst_cmd_addr", 72'(mem_cmd_addr), 72'd0);
                check("mid_rst_num_col", 72'(fifo_num_col), 72'd0);
                repeat (2) @(posedge clk);
                #1;
                pending = 0;
                rst_n   = 1'b1;
            end
        join
        abort = 0;
        repeat (2) @(posedge clk);
        run_job(32'h1000, 32'h40, 2, 15, 0, 0, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
